// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared decode constants and enums for the EXE-stage
// multiply/divide unit (exe_muldiv) and its single-step datapath (muldiv_iter).
// Contents:
//   OPC_SPECIAL        SPECIAL opcode, instruction[31:26]
//   FUNCT_*            funct field encodings, instruction[5:0]
//   muldiv_state_t     FSM states IDLE / RUN / FIX
//   muldiv_op_t        datapath operation OP_MUL / OP_DIV
package muldiv_pkg;

    localparam logic [5:0] OPC_SPECIAL = 6'h00;

    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } muldiv_op_t;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: combinational single iteration of the multiply/divide datapath.
// The 2*XLEN accumulator is {upper half, lower half}:
//   multiply: {partial product, remaining multiplier bits}, shift-add step
//   divide:   {partial remainder, remaining dividend / quotient bits},
//             restoring shift-subtract step
// Ports:
//   acc       in  2*XLEN  current accumulator
//   operand   in  XLEN    multiplicand or divisor magnitude
//   op        in  1       OP_MUL / OP_DIV
//   acc_next  out 2*XLEN  accumulator after this step (bit 0 left 0 for divide)
//   q_bit     out 1       quotient bit produced by a divide step (0 for multiply)
// Build option: MULDIV_DIV_EN defined compiles in the divide step; otherwise
// only the multiply step exists and OP_DIV leaves the accumulator unchanged.
module muldiv_iter
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2*XLEN-1:0] acc,
    input  logic [XLEN-1:0]   operand,
    input  muldiv_op_t        op,
    output logic [2*XLEN-1:0] acc_next,
    output logic              q_bit
);

    logic [XLEN:0] sum_s;
`ifdef MULDIV_DIV_EN
    logic [XLEN:0] shift_s;
    logic [XLEN:0] diff_s;
`endif

    // One shift-add or restoring shift-subtract step
    always_comb begin
        sum_s    = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, operand};
        acc_next = acc;
        q_bit    = 1'b0;
`ifdef MULDIV_DIV_EN
        shift_s  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff_s   = shift_s - {1'b0, operand};
`endif
        case (op)
            OP_MUL: begin
                // The carry out of the add becomes the new top bit after the shift.
                if (acc[0]) begin
                    acc_next = {sum_s, acc[XLEN-1:1]};
                end else begin
                    acc_next = {1'b0, acc[2*XLEN-1:1]};
                end
            end
`ifdef MULDIV_DIV_EN
            OP_DIV: begin
                // diff_s[XLEN] set means the trial subtraction borrowed: restore.
                if (!diff_s[XLEN]) begin
                    acc_next = {diff_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                    q_bit    = 1'b1;
                end else begin
                    acc_next = {shift_s[XLEN-1:0], acc[XLEN-2:0], 1'b0};
                    q_bit    = 1'b0;
                end
            end
`endif
            default: begin
                acc_next = acc;
                q_bit    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/exe_muldiv.sv
// exe_muldiv: iterative MIPS mult/multu/div/divu unit in the EXE stage, owner
// of the architectural HI/LO registers (also written by mthi/mtlo).
// A mult/div takes 32 RUN cycles plus one FIX cycle; busy stalls the ID/EXE
// buffer (go = ~busy) for that whole time.
// Ports:
//   clk          in  1     clock, all state on posedge
//   rst          in  1     synchronous active-high reset
//   start        in  1     ID/EXE output valid this cycle
//   clear        in  1     flush: abort any operation, HI/LO untouched
//   instruction  in  32    opcode [31:26], funct [5:0] decoded
//   A, B         in  XLEN  rs / rt operands
//   busy         out 1     operation in flight (registered)
//   done         out 1     high in the FIX cycle, HI/LO written at its end
//   hi, lo       out XLEN  architectural HI / LO (registered)
// Build option: MULDIV_DIV_EN enables div/divu; without it they are no-ops.
module exe_muldiv
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            clear,
    input  logic [31:0]     instruction,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    muldiv_state_t      state_r;
    logic [CW-1:0]      cnt_r;
    muldiv_op_t         op_r;
    logic               neg_r;
    logic [2*XLEN-1:0]  acc_r;
    logic [XLEN-1:0]    opnd_r;
    logic [XLEN-1:0]    hi_r;
    logic [XLEN-1:0]    lo_r;
    logic               busy_r;
    logic               done_r;
`ifdef MULDIV_DIV_EN
    logic               rem_neg_r;
    logic               bzero_r;
    logic [XLEN-1:0]    a_orig_r;
`endif

    logic [5:0]         funct_s;
    logic               special_s;
    logic               dec_mul_s;
    logic               dec_div_s;
    logic               dec_signed_s;
    logic               dec_mthi_s;
    logic               dec_mtlo_s;
    logic               unused_instr_s;
    logic               a_neg_s;
    logic               b_neg_s;
    logic [XLEN-1:0]    a_mag_s;
    logic [XLEN-1:0]    b_mag_s;
    logic [2*XLEN-1:0]  iter_acc_s;
    logic               iter_q_s;
    logic [2*XLEN-1:0]  fix_prod_s;
    logic [XLEN-1:0]    fix_hi_s;
    logic [XLEN-1:0]    fix_lo_s;

    assign funct_s        = instruction[5:0];
    assign special_s      = (instruction[31:26] == OPC_SPECIAL);
    assign unused_instr_s = ^instruction[25:6];
    assign dec_mul_s      = special_s && ((funct_s == FUNCT_MULT) || (funct_s == FUNCT_MULTU));
`ifdef MULDIV_DIV_EN
    assign dec_div_s      = special_s && ((funct_s == FUNCT_DIV) || (funct_s == FUNCT_DIVU));
`else
    assign dec_div_s      = 1'b0;
`endif
    assign dec_signed_s   = (funct_s == FUNCT_MULT) || (funct_s == FUNCT_DIV);
    assign dec_mthi_s     = special_s && (funct_s == FUNCT_MTHI);
    assign dec_mtlo_s     = special_s && (funct_s == FUNCT_MTLO);

    // Operand magnitudes: the iteration always works on unsigned values.
    assign a_neg_s = dec_signed_s && A[XLEN-1];
    assign b_neg_s = dec_signed_s && B[XLEN-1];
    assign a_mag_s = a_neg_s ? -A : A;
    assign b_mag_s = b_neg_s ? -B : B;

    muldiv_iter #(.XLEN(XLEN)) u_iter (
        .acc      (acc_r),
        .operand  (opnd_r),
        .op       (op_r),
        .acc_next (iter_acc_s),
        .q_bit    (iter_q_s)
    );

    // Sign correction and divide-by-zero override applied in FIX
    always_comb begin
        fix_prod_s = neg_r ? -acc_r : acc_r;
        fix_hi_s   = fix_prod_s[2*XLEN-1:XLEN];
        fix_lo_s   = fix_prod_s[XLEN-1:0];
`ifdef MULDIV_DIV_EN
        if (op_r == OP_DIV) begin
            if (bzero_r) begin
                fix_lo_s = {XLEN{1'b1}};
                fix_hi_s = a_orig_r;
            end else begin
                fix_lo_s = neg_r     ? -acc_r[XLEN-1:0]      : acc_r[XLEN-1:0];
                fix_hi_s = rem_neg_r ? -acc_r[2*XLEN-1:XLEN] : acc_r[2*XLEN-1:XLEN];
            end
        end else begin
            fix_hi_s = fix_prod_s[2*XLEN-1:XLEN];
            fix_lo_s = fix_prod_s[XLEN-1:0];
        end
`endif
    end

    // Control FSM, iteration registers and architectural HI/LO
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            cnt_r     <= {CW{1'b0}};
            op_r      <= OP_MUL;
            neg_r     <= 1'b0;
            acc_r     <= {(2*XLEN){1'b0}};
            opnd_r    <= {XLEN{1'b0}};
            hi_r      <= {XLEN{1'b0}};
            lo_r      <= {XLEN{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
`ifdef MULDIV_DIV_EN
            rem_neg_r <= 1'b0;
            bzero_r   <= 1'b0;
            a_orig_r  <= {XLEN{1'b0}};
`endif
        end else if (clear) begin
            // Flush wins over a simultaneous start; HI/LO keep their values.
            state_r <= IDLE;
            cnt_r   <= {CW{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start && (dec_mul_s || dec_div_s)) begin
                        state_r   <= RUN;
                        busy_r    <= 1'b1;
                        cnt_r     <= {CW{1'b0}};
                        op_r      <= dec_div_s ? OP_DIV : OP_MUL;
                        neg_r     <= a_neg_s ^ b_neg_s;
                        acc_r     <= {{XLEN{1'b0}}, a_mag_s};
                        opnd_r    <= b_mag_s;
`ifdef MULDIV_DIV_EN
                        rem_neg_r <= a_neg_s;
                        bzero_r   <= (B == {XLEN{1'b0}});
                        a_orig_r  <= A;
`endif
                    end else if (start && dec_mthi_s) begin
                        hi_r <= A;
                    end else if (start && dec_mtlo_s) begin
                        lo_r <= A;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                RUN: begin
                    acc_r <= {iter_acc_s[2*XLEN-1:1], iter_acc_s[0] | iter_q_s};
                    cnt_r <= cnt_r + CNT_ONE;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= FIX;
                        done_r  <= 1'b1;
                    end else begin
                        done_r  <= 1'b0;
                    end
                end
                FIX: begin
                    hi_r    <= fix_hi_s;
                    lo_r    <= fix_lo_s;
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_exe_muldiv.sv
// tb_exe_muldiv: self-checking bench for exe_muldiv. Expected HI/LO come from
// plain SystemVerilog arithmetic on the operands; expected timing is the
// 33-cycle busy window with a single done pulse.
module tb_exe_muldiv;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        rst, start, clear;
    logic [31:0] instruction, A, B;
    logic        busy, done;
    logic [31:0] hi, lo;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_hi   = 32'h0;
    logic [31:0] exp_lo   = 32'h0;

    exe_muldiv dut (
        .clk(clk), .rst(rst), .start(start), .clear(clear),
        .instruction(instruction), .A(A), .B(B),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: architectural result of one instruction on HI/LO.
    task automatic model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        int          sa, sb;
        longint      sp;
        logic [63:0] p;
        sa = a;
        sb = b;
        case (f)
            FUNCT_MULT:  begin sp = longint'(sa) * longint'(sb); p = sp; exp_hi = p[63:32]; exp_lo = p[31:0]; end
            FUNCT_MULTU: begin p = {32'h0, a} * {32'h0, b}; exp_hi = p[63:32]; exp_lo = p[31:0]; end
`ifdef MULDIV_DIV_EN
            FUNCT_DIV: begin
                if (b == 32'h0) begin exp_lo = 32'hFFFFFFFF; exp_hi = a; end
                else begin exp_lo = sa / sb; exp_hi = sa % sb; end
            end
            FUNCT_DIVU: begin
                if (b == 32'h0) begin exp_lo = 32'hFFFFFFFF; exp_hi = a; end
                else begin exp_lo = a / b; exp_hi = a % b; end
            end
`endif
            FUNCT_MTHI: exp_hi = a;
            FUNCT_MTLO: exp_lo = a;
            default: ;
        endcase
    endtask

    task automatic issue(input logic [5:0] opc, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        instruction = {opc, 20'h0, f};
        A = a;
        B = b;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Issue and follow an instruction until busy drops (bounded), counting cycles.
    task automatic run_op(input logic [5:0] opc, input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b, output int busy_cnt, output int done_cnt);
        issue(opc, f, a, b);
        busy_cnt = 0;
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) done_cnt++;
            if (busy !== 1'b1) break;
            step();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; clear = 1'b0; instruction = 32'h0; A = 32'h0; B = 32'h0;
        step(); step();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h expected 0", hi); end
        n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h expected 0", lo); end
        exp_hi = 32'h0; exp_lo = 32'h0;
    endtask

    task automatic test_mul_directed();
        int bc, dc;
        run_op(OPC_SPECIAL, FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, bc, dc);
        model(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL multu_done_pulses: got %0d expected 1", dc); end
        n_checks++; if (hi !== 32'hFFFFFFFE) begin n_fail++; $display("FAIL multu_hi: got %h expected fffffffe", hi); end
        n_checks++; if (lo !== 32'h00000001) begin n_fail++; $display("FAIL multu_lo: got %h expected 00000001", lo); end
        run_op(OPC_SPECIAL, FUNCT_MULT, 32'hFFFFFFFD, 32'h5, bc, dc);
        model(FUNCT_MULT, 32'hFFFFFFFD, 32'h5);
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL mult_neg_hi: got %h expected ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFFFFF1) begin n_fail++; $display("FAIL mult_neg_lo: got %h expected fffffff1", lo); end
    endtask

`ifdef MULDIV_DIV_EN
    task automatic test_div_directed();
        int bc, dc;
        run_op(OPC_SPECIAL, FUNCT_DIV, 32'hFFFFFFF9, 32'h2, bc, dc);
        model(FUNCT_DIV, 32'hFFFFFFF9, 32'h2);
        n_checks++; if (bc != 33) begin n_fail++; $display("FAIL div_busy_cycles: got %0d expected 33", bc); end
        n_checks++; if (lo !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL div_neg_lo: got %h expected fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL div_neg_hi: got %h expected ffffffff", hi); end
        run_op(OPC_SPECIAL, FUNCT_DIVU, 32'h7, 32'h0, bc, dc);
        model(FUNCT_DIVU, 32'h7, 32'h0);
        n_checks++; if (dc != 1) begin n_fail++; $display("FAIL divu0_done_pulses: got %0d expected 1", dc); end
        n_checks++; if (lo !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL divu0_lo: got %h expected ffffffff", lo); end
        n_checks++; if (hi !== 32'h00000007) begin n_fail++; $display("FAIL divu0_hi: got %h expected 00000007", hi); end
    endtask
`else
    task automatic test_div_disabled();
        int bc, dc;
        run_op(OPC_SPECIAL, FUNCT_DIV, 32'h8, 32'h2, bc, dc);
        n_checks++; if (bc != 0) begin n_fail++; $display("FAIL div_off_busy: got %0d cycles expected 0", bc); end
        n_checks++; if (dc != 0) begin n_fail++; $display("FAIL div_off_done: got %0d pulses expected 0", dc); end
        n_checks++; if (hi !== exp_hi) begin n_fail++; $display("FAIL div_off_hi: got %h expected %h", hi, exp_hi); end
        n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL div_off_lo: got %h expected %h", lo, exp_lo); end
    endtask
`endif

    task automatic test_random();
        logic [5:0]  ops [4];
        logic [5:0]  f;
        logic [31:0] a, b;
        int          bc, dc, n_ops;
        ops[0] = FUNCT_MULT; ops[1] = FUNCT_MULTU; ops[2] = FUNCT_DIV; ops[3] = FUNCT_DIVU;
`ifdef MULDIV_DIV_EN
        n_ops = 4;
`else
        n_ops = 2;
`endif
        for (int i = 0; i < 24; i++) begin
            f = ops[$urandom_range(0, n_ops - 1)];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'h0;
                1: b = $urandom_range(1, 9);
                2: a = -$urandom_range(0, 1000);
                default: ;
            endcase
            if (f == FUNCT_DIV && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'h1;
            run_op(OPC_SPECIAL, f, a, b, bc, dc);
            model(f, a, b);
            n_checks++; if (bc != 33 || dc != 1) begin n_fail++; $display("FAIL rand_timing f=%h: busy %0d done %0d expected 33/1", f, bc, dc); end
            n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin
                n_fail++; $display("FAIL rand_result f=%h a=%h b=%h: got %h_%h expected %h_%h", f, a, b, hi, lo, exp_hi, exp_lo);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] v;
        issue(OPC_SPECIAL, FUNCT_MTHI, 32'h12345678, 32'h0);
        model(FUNCT_MTHI, 32'h12345678, 32'h0);
        n_checks++; if (hi !== 32'h12345678) begin n_fail++; $display("FAIL mthi_hi: got %h expected 12345678", hi); end
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mthi_busy_done: got %b%b expected 00", busy, done); end
        n_checks++; if (lo !== exp_lo) begin n_fail++; $display("FAIL mthi_lo_kept: got %h expected %h", lo, exp_lo); end
        v = $urandom;
        issue(OPC_SPECIAL, FUNCT_MTLO, v, 32'h0);
        model(FUNCT_MTLO, v, 32'h0);
        n_checks++; if (lo !== v || hi !== exp_hi) begin n_fail++; $display("FAIL mtlo: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
    endtask

    task automatic test_start_during_run();
        int bc, dc;
        issue(OPC_SPECIAL, FUNCT_MULT, 32'h2, 32'h2);
        model(FUNCT_MULT, 32'h2, 32'h2);
        bc = 0; dc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) bc++;
            if (done === 1'b1) dc++;
            if (busy !== 1'b1) break;
            if (i == 4) begin instruction = {OPC_SPECIAL, 20'h0, FUNCT_MULT}; A = 32'h9; B = 32'h9; start = 1'b1; end
            else start = 1'b0;
            step();
        end
        start = 1'b0;
        n_checks++; if (bc != 33 || dc != 1) begin n_fail++; $display("FAIL start_in_run_timing: busy %0d done %0d expected 33/1", bc, dc); end
        n_checks++; if (lo !== 32'h4 || hi !== 32'h0) begin n_fail++; $display("FAIL start_in_run_result: got %h_%h expected 00000000_00000004", hi, lo); end
    endtask

    task automatic test_clear();
        int seen_busy, seen_done;
        issue(OPC_SPECIAL, FUNCT_MTHI, 32'hCAFE0001, 32'h0); model(FUNCT_MTHI, 32'hCAFE0001, 32'h0);
        issue(OPC_SPECIAL, FUNCT_MTLO, 32'hBEEF0002, 32'h0); model(FUNCT_MTLO, 32'hBEEF0002, 32'h0);
        issue(OPC_SPECIAL, FUNCT_MULTU, 32'h3, 32'h4);
        for (int i = 0; i < 9; i++) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL clear_busy: got %b expected 0", busy); end
        seen_busy = 0; seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) seen_busy++;
            if (done === 1'b1) seen_done++;
            step();
        end
        n_checks++; if (seen_done != 0 || seen_busy != 0) begin n_fail++; $display("FAIL clear_aftermath: busy %0d done %0d expected 0/0", seen_busy, seen_done); end
        n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL clear_hilo_kept: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
        // clear together with start in IDLE drops the start
        instruction = {OPC_SPECIAL, 20'h0, FUNCT_MULT}; A = 32'h5; B = 32'h5;
        start = 1'b1; clear = 1'b1;
        step();
        start = 1'b0; clear = 1'b0;
        step();
        n_checks++; if (busy !== 1'b0 || hi !== exp_hi || lo !== exp_lo) begin
            n_fail++; $display("FAIL clear_with_start: busy %b hilo %h_%h expected 0 %h_%h", busy, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_back_to_back();
        int bc, dc;
        logic [31:0] a2, b2;
        run_op(OPC_SPECIAL, FUNCT_MULT, 32'hFFFF0000, 32'h00012345, bc, dc);
        model(FUNCT_MULT, 32'hFFFF0000, 32'h00012345);
        n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL b2b_first: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
        a2 = $urandom; b2 = $urandom;
        run_op(OPC_SPECIAL, FUNCT_MULTU, a2, b2, bc, dc);
        model(FUNCT_MULTU, a2, b2);
        n_checks++; if (bc != 33 || dc != 1) begin n_fail++; $display("FAIL b2b_timing: busy %0d done %0d expected 33/1", bc, dc); end
        n_checks++; if (hi !== exp_hi || lo !== exp_lo) begin n_fail++; $display("FAIL b2b_second: got %h_%h expected %h_%h", hi, lo, exp_hi, exp_lo); end
    endtask

    task automatic test_noop();
        int bc, dc;
        run_op(6'h23, 6'h00, 32'h1111, 32'h2222, bc, dc);
        n_checks++; if (bc != 0) begin n_fail++; $display("FAIL noop_opcode_busy: got %0d cycles expected 0", bc); end
        run_op(OPC_SPECIAL, 6'h10, 32'h1111, 32'h2222, bc, dc);
        n_checks++; if (bc != 0 || hi !== exp_hi || lo !== exp_lo) begin
            n_fail++; $display("FAIL noop_mfhi: busy %0d hilo %h_%h expected 0 %h_%h", bc, hi, lo, exp_hi, exp_lo);
        end
    endtask

    task automatic test_rst_mid();
`ifdef MULDIV_DIV_EN
        issue(OPC_SPECIAL, FUNCT_DIVU, 32'hDEADBEEF, 32'h00000013);
`else
        issue(OPC_SPECIAL, FUNCT_MULTU, 32'hDEADBEEF, 32'h00000013);
`endif
        for (int i = 0; i < 19; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            n_fail++; $display("FAIL rst_mid_op: busy %b done %b hilo %h_%h expected 0 0 0_0", busy, done, hi, lo);
        end
        exp_hi = 32'h0; exp_lo = 32'h0;
    endtask

    initial begin
        test_reset();
        test_mul_directed();
`ifdef MULDIV_DIV_EN
        test_div_directed();
`else
        test_div_disabled();
`endif
        test_mthi_mtlo();
        test_random();
        test_start_during_run();
        test_clear();
        test_back_to_back();
        test_noop();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
